avr_rx: RTL and testbench
=========================

Name: avr_rx

Overview:
- Serial receiver for the AVR link; it is the receive-side counterpart of the existing AVR transmitter.
- Samples the asynchronous rx line (8N1, LSB first, idle high) and presents each received byte with a one-cycle new_data strobe.
- Sits between the AVR rx pin and the command/packet parser.
- Reports stop-bit failures on frame_err.

Parameters:
- CLK_PER_BIT, 50: clk cycles per serial bit. Minimum 4 (minimum 8 with AVR_RX_MAJORITY_EN).
- CTR_SIZE, $clog2(CLK_PER_BIT): bit-timer width. Derived; never overridden.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  raw serial line from the AVR; asynchronous to clk.
- data  out  8  last correctly framed byte; held until the next good frame.
- new_data  out  1  one-cycle pulse when data updates.
- frame_err  out  1  one-cycle pulse when the stop bit samples low.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, ctr=0, bit_ctr=0.
  - data=8'h00, new_data=0, frame_err=0, busy=0.
  - Both synchronizer flops set to 1.
  - Takes effect immediately, including mid-frame; the partial byte is discarded.
- Synchronizer: rx passes through 2 flops to form rx_s. Only rx_s is used by logic.
- Timing constants: H = CLK_PER_BIT/2, truncated. C = CLK_PER_BIT.
- IDLE:
  - Hold ctr=0, bit_ctr=0.
  - rx_s==0 -> START_BIT, ctr=0.
- START_BIT:
  - ctr increments each cycle.
  - At ctr==H-1, sample rx_s:
    - 1 -> IDLE (glitch rejected; no output pulse).
    - 0 -> DATA, ctr=0.
- DATA:
  - ctr increments each cycle.
  - At ctr==C-1: shift the sample into the data shift register MSB (shift right, LSB first), ctr=0, bit_ctr++.
  - The sample for bit_ctr==7 moves the FSM to STOP_BIT.
- STOP_BIT:
  - At ctr==C-1, sample rx_s:
    - 1 -> data <= shift register, new_data=1 for one cycle.
    - 0 -> frame_err=1 for one cycle, data unchanged.
  - Either case -> IDLE the next cycle.
  - Exiting at mid stop bit leaves half a bit of margin, so back-to-back frames with zero idle are received.
- Latency: new_data is high in the cycle after clk edge 3+H+9C, counted from the first edge at which the pin is low. For C=50 this is edge 478.
- new_data and frame_err are registered, mutually exclusive, and never high for two consecutive cycles.
- rx stuck low (break):
  - One frame_err is reported, then FSM -> IDLE.
  - It re-enters START_BIT, and the next frame_err comes one frame later. Break repeats frame_err every ~10 bit times.
- ctr and bit_ctr wrap only through explicit clears; no reliance on natural overflow.

Optional Feature:
- Macro: AVR_RX_MAJORITY_EN.
- Defined:
  - A 3-deep history of rx_s is kept.
  - Every sample point (start check, data bits, stop bit) uses the majority of the last 3 rx_s values instead of the single rx_s.
  - Rejects single-cycle glitches. Adds no latency to the strobe timing.
- Undefined: single rx_s sample, with no extra flops.

Decomposition:
- Shared package avr_pkg holds:
  - State localparams IDLE/START_BIT/DATA/STOP_BIT (2 bits), shared with the transmitter.
  - The default CLK_PER_BIT constant.
- One natural sub-module: sync_2ff, the 2-flop synchronizer with asynchronous active-low reset to a parameterized value. It is reusable for other asynchronous pins.
- Everything else is inline in one FSM, split into combinational next-state and registered blocks.

Test Plan:
- Frame 0xA5, C=50, idle before and after -> new_data single pulse at edge 478, data=0xA5, frame_err=0, busy high from edge 3 until IDLE.
- Back-to-back 0x00 then 0xFF, zero idle between stop and start -> two new_data pulses ~500 cycles apart, data=0x00 then 0xFF.
- rx low for 10 cycles then high -> busy pulses briefly, returns to IDLE, no new_data and no frame_err.
- Frame 0x3C with stop bit driven low (after prior good 0x11) -> frame_err one pulse, new_data 0, data stays 0x11.
- rst low mid-DATA of 0x77 -> data=0, busy=0 immediately, without waiting for clk. After release, a clean 0x5A -> data=0x5A.
- 0x00 with a one-cycle high glitch aligned to the bit-3 sample point -> data=0x00 with AVR_RX_MAJORITY_EN, 0x08 without.

Source files
------------

// File: rtl/avr_pkg.sv
// avr_pkg: definitions shared by the AVR link transmitter and receiver.
//   - AVR_CLK_PER_BIT : default clk cycles per serial bit
//   - IDLE/START_BIT/DATA/STOP_BIT : 2-bit state codes common to both directions
//   - avr_state_e : enum view of the same codes for FSM registers
//   - majority3() : 2-of-3 vote used by the optional glitch filter
package avr_pkg;

  localparam int AVR_CLK_PER_BIT = 50;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START_BIT = 2'd1;
  localparam logic [1:0] DATA      = 2'd2;
  localparam logic [1:0] STOP_BIT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_START = START_BIT,
    ST_DATA  = DATA,
    ST_STOP  = STOP_BIT
  } avr_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/avr_rx_sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input pin.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronized output (two clk cycles of latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/avr_rx.sv
// avr_rx: 8N1 serial receiver for the AVR link (LSB first, idle high).
//   clk       : system clock, all logic on posedge
//   rst       : asynchronous active-low reset
//   rx        : raw serial line, asynchronous to clk
//   data      : last correctly framed byte, held until the next good frame
//   new_data  : one-cycle pulse when data updates
//   frame_err : one-cycle pulse when the stop bit samples low
//   busy      : high whenever the FSM is not idle
// Build option: define AVR_RX_MAJORITY_EN to take every sample point as the
// 2-of-3 majority of the last three synchronized rx values (needs
// CLK_PER_BIT >= 8). Without it a single synchronized sample is used.
module avr_rx
  import avr_pkg::*;
#(
  parameter int CLK_PER_BIT = AVR_CLK_PER_BIT,
  parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       new_data,
  output logic       frame_err,
  output logic       busy
);

  // Mid-bit offset for the start check, full bit period for data/stop.
  localparam logic [CTR_SIZE-1:0] H_M1 = CTR_SIZE'(CLK_PER_BIT / 2 - 1);
  localparam logic [CTR_SIZE-1:0] C_M1 = CTR_SIZE'(CLK_PER_BIT - 1);

  logic rx_s;
  logic sample;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef AVR_RX_MAJORITY_EN
  // The vote window ends on the current rx_s, so the sample instant is
  // unchanged and strobe timing matches the single-sample build.
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = {hist_q[0], rx_s};
    sample = majority3(rx_s, hist_q[0], hist_q[1]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hist_q <= 2'b11;
    else      hist_q <= hist_d;
  end
`else
  always_comb sample = rx_s;
`endif

  avr_state_e          state_q, state_d;
  logic [CTR_SIZE-1:0] ctr_q, ctr_d;
  logic [2:0]          bit_ctr_q, bit_ctr_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          data_q, data_d;
  logic                new_data_q, new_data_d;
  logic                frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    bit_ctr_d   = bit_ctr_q;
    shift_d     = shift_q;
    data_d      = data_q;
    new_data_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ctr_d     = '0;
        bit_ctr_d = 3'd0;
        // Edge detect uses the plain synchronized line; the start check
        // half a bit later decides whether it was a real start bit.
        if (!rx_s) state_d = ST_START;
      end

      ST_START: begin
        if (ctr_q == H_M1) begin
          ctr_d   = '0;
          state_d = sample ? ST_IDLE : ST_DATA;
        end else begin
          ctr_d = ctr_q + CTR_SIZE'(1);
        end
      end

      ST_DATA: begin
        if (ctr_q == C_M1) begin
          ctr_d   = '0;
          shift_d = {sample, shift_q[7:1]};
          if (bit_ctr_q == 3'd7) begin
            bit_ctr_d = 3'd0;
            state_d   = ST_STOP;
          end else begin
            bit_ctr_d = bit_ctr_q + 3'd1;
          end
        end else begin
          ctr_d = ctr_q + CTR_SIZE'(1);
        end
      end

      ST_STOP: begin
        // Leaving at mid stop bit gives half a bit of slack, enough to catch
        // a start edge that follows the stop bit with no idle time.
        if (ctr_q == C_M1) begin
          ctr_d   = '0;
          state_d = ST_IDLE;
          if (sample) begin
            data_d     = shift_q;
            new_data_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          ctr_d = ctr_q + CTR_SIZE'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        ctr_d     = '0;
        bit_ctr_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ctr_q       <= '0;
      bit_ctr_q   <= 3'd0;
      data_q      <= 8'h00;
      new_data_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      bit_ctr_q   <= bit_ctr_d;
      data_q      <= data_d;
      new_data_q  <= new_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Every bit is overwritten before a frame can be committed, so the shift
  // register needs no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign data      = data_q;
  assign new_data  = new_data_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_avr_rx.sv
// tb_avr_rx: self-checking bench for avr_rx.
// The reference model is a list of expected receive windows derived from
// frame timing: a frame whose first low pin sample is at edge t1 keeps busy
// high for cycles [t1+2, t1+2+H+9C) and strobes at cycle t1+2+H+9C; a
// rejected start is busy for [t1+2, t1+2+H).
module tb_avr_rx;

  localparam int C = 50;
  localparam int H = C / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       new_data;
  logic       frame_err;
  logic       busy;

  avr_rx #(.CLK_PER_BIT(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .new_data  (new_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         s;
    int         e;
    int         kind;   // 0: no strobe, 1: new_data, 2: frame_err
    logic [7:0] b;
  } win_t;

  win_t       win[$];
  logic [7:0] model_data = 8'h00;
  int         tests = 0;
  int         fails = 0;
  int         nd_cnt = 0;
  int         fe_cnt = 0;
  int         last_nd = -1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic add_win(input int s, input int e, input int kind, input logic [7:0] b);
    win_t w;
    w.s = s; w.e = e; w.kind = kind; w.b = b;
    win.push_back(w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  // Drives one 10-bit frame, one pin value per clock edge.
  task automatic send_frame(input logic [7:0] b, input logic [7:0] exp_b,
                            input bit stop_bad, input int glitch_p, output int t1);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    t1 = cyc + 1;
    add_win(t1 + 2, t1 + 2 + H + 9 * C, stop_bad ? 2 : 1, exp_b);
    for (int p = 0; p < 10 * C; p++) begin
      rx = bits[p / C];
      if (stop_bad && p >= 9 * C && p <= 9 * C + H) rx = 1'b0;
      if (p == glitch_p) rx = 1'b1;
      step();
    end
    rx = 1'b1;
  endtask

  bit eb, en, ef;
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_new_data", new_data, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_data", data, 0);
    end else begin
      eb = 1'b0; en = 1'b0; ef = 1'b0;
      foreach (win[i]) begin
        if (cyc >= win[i].s && cyc < win[i].e) eb = 1'b1;
        if (cyc == win[i].e) begin
          if (win[i].kind == 1) begin
            en = 1'b1;
            model_data = win[i].b;
          end else if (win[i].kind == 2) begin
            ef = 1'b1;
          end
        end
      end
      chk("busy", busy, eb);
      chk("new_data", new_data, en);
      chk("frame_err", frame_err, ef);
      chk("data", data, model_data);
      if (new_data) begin
        nd_cnt++;
        last_nd = cyc;
      end
      if (frame_err) fe_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  int         t1, e1, e2, t1b, nd0, fe0;
  logic [7:0] gexp;

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    idle(20);

    // Single frame 0xA5 with idle around it.
    send_frame(8'hA5, 8'hA5, 1'b0, -1, t1);
    idle(30);
    chk("a5_latency_edge", last_nd - t1 + 1, 478);
    chk("a5_data", data, 8'hA5);
    chk("a5_nd_count", nd_cnt, 1);
    chk("a5_fe_count", fe_cnt, 0);

    // Back-to-back 0x00 then 0xFF, no idle between.
    nd0 = nd_cnt;
    send_frame(8'h00, 8'h00, 1'b0, -1, t1);
    send_frame(8'hFF, 8'hFF, 1'b0, -1, t1b);
    idle(30);
    chk("b2b_nd_count", nd_cnt - nd0, 2);
    chk("b2b_data", data, 8'hFF);

    // Short low pulse: start rejected, no strobe.
    nd0 = nd_cnt;
    t1 = cyc + 1;
    add_win(t1 + 2, t1 + 2 + H, 0, 8'h00);
    rx = 1'b0;
    repeat (10) step();
    idle(60);
    chk("glitch_start_nd", nd_cnt - nd0, 0);
    chk("glitch_start_fe", fe_cnt, 0);

    // Good 0x11, then 0x3C with a low stop bit.
    send_frame(8'h11, 8'h11, 1'b0, -1, t1);
    idle(20);
    nd0 = nd_cnt;
    send_frame(8'h3C, 8'h11, 1'b1, -1, t1);
    idle(30);
    chk("stop_bad_data", data, 8'h11);
    chk("stop_bad_fe_count", fe_cnt, 1);
    chk("stop_bad_nd", nd_cnt - nd0, 0);

    // Reset in the middle of the data bits of 0x77.
    t1 = cyc + 1;
    add_win(t1 + 2, t1 + 2 + H + 9 * C, 0, 8'h00);
    rx = 1'b0;
    repeat (C) step();
    rx = 1'b1;
    repeat (3 * C) step();
    rst = 1'b0;
    win.delete();
    model_data = 8'h00;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_data", data, 8'h00);
    chk("async_rst_nd", new_data, 0);
    repeat (3) step();
    rst = 1'b1;
    idle(20);
    send_frame(8'h5A, 8'h5A, 1'b0, -1, t1);
    idle(30);
    chk("post_rst_data", data, 8'h5A);

    // 0x00 with a one-cycle high glitch on the bit-3 sample point.
`ifdef AVR_RX_MAJORITY_EN
    gexp = 8'h00;
`else
    gexp = 8'h08;
`endif
    send_frame(8'h00, gexp, 1'b0, 4 * C + H, t1);
    idle(30);
`ifdef AVR_RX_MAJORITY_EN
    chk("bit3_glitch_data", data, 8'h00);
`else
    chk("bit3_glitch_data", data, 8'h08);
`endif

    // Break: line held low for two frame periods.
    fe0 = fe_cnt;
    nd0 = nd_cnt;
    t1  = cyc + 1;
    e1  = t1 + 2 + H + 9 * C;
    t1b = t1 + 1 + H + 9 * C;
    e2  = t1b + 2 + H + 9 * C;
    add_win(t1 + 2, e1, 2, 8'h00);
    add_win(e1 + 1, e2, 2, 8'h00);
    rx = 1'b0;
    while (cyc < e2 - 2) step();
    rx = 1'b1;
    idle(60);
    chk("break_fe_count", fe_cnt - fe0, 2);
    chk("break_nd_count", nd_cnt - nd0, 0);
    chk("break_data_held", data, gexp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
